aes128_encryptor: RTL and testbench

Iterative AES-128 (FIPS-197) encryption core: one 128-bit plaintext block and one 128-bit cipher key in, one 128-bit ciphertext block out. Computes one round per clock with on-the-fly key expansion, so no round-key storage is needed. Used by the crypto datapath as a single-block encrypt engine with a start/done handshake.

---
 rtl/aes128_encryptor.sv | 175 +++++++++++++++++
 tb/tb_aes128_encryptor.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/aes128_encryptor.sv
// Iterative AES-128 encryption core, one round per clock with on-the-fly key expansion.
// Define AES_UNROLL2_EN to compute two rounds per clock (6-cycle instead of 11-cycle latency).
module aes128_encryptor (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext,
  output logic         done
);

`ifdef AES_UNROLL2_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif

  // Round counter value that marks "all ten rounds applied, publish the result".
  localparam logic [3:0] ROUND_PUBLISH = 4'd11;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, FIN} fsm_t;

  fsm_t         fsm_reg, fsm_next;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [3:0]   round_reg;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon_fn(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Chains the four words of the next round key from the transformed last word.
  function automatic logic [127:0] expand(input logic [127:0] k, input logic [31:0] t);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  genvar gi, gb;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_step
      logic [127:0] s_in, k_in, s_sb, s_sr, s_mc, s_out, k_out;
      logic [31:0]  rot_word, sub_word;
      logic [3:0]   rnd;

      if (gi == 0) begin : g_first
        assign s_in = state_reg;
        assign k_in = key_reg;
      end else begin : g_chain
        assign s_in = g_step[gi-1].s_out;
        assign k_in = g_step[gi-1].k_out;
      end

      assign rnd = round_reg + 4'(gi);

      // SubBytes then ShiftRows: byte (row r, col c) takes byte (r, c+r mod 4).
      for (gb = 0; gb < 16; gb++) begin : g_byte
        localparam int SRC = 4 * (((gb / 4) + (gb % 4)) % 4) + (gb % 4);
        assign s_sb[127-8*gb -: 8] = sbox(s_in[127-8*gb -: 8]);
        assign s_sr[127-8*gb -: 8] = s_sb[127-8*SRC -: 8];
      end

      for (gb = 0; gb < 4; gb++) begin : g_col
        assign s_mc[127-32*gb -: 32] = mix_col(s_sr[127-32*gb -: 32]);
        assign sub_word[31-8*gb -: 8] = sbox(rot_word[31-8*gb -: 8]);
      end

      assign rot_word = {k_in[23:0], k_in[31:24]};
      assign k_out    = expand(k_in, sub_word ^ {rcon_fn(rnd), 24'h000000});
      assign s_out    = ((rnd == 4'd10) ? s_sr : s_mc) ^ k_out;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_reg <= IDLE;
    else     fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      IDLE, FIN: if (start) fsm_next = RUN;
      RUN:       if (round_reg == ROUND_PUBLISH) fsm_next = FIN;
      default:   fsm_next = IDLE;
    endcase
  end

  // The round counter overshoots to 11 so the final state is published one cycle after round 10.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= '0;
      key_reg    <= '0;
      round_reg  <= '0;
      ciphertext <= '0;
      done       <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE, FIN: begin
          if (start) begin
            state_reg <= plaintext ^ key;
            key_reg   <= key;
            round_reg <= 4'd1;
            done      <= 1'b0;
          end
        end
        RUN: begin
          if (round_reg == ROUND_PUBLISH) begin
            ciphertext <= state_reg;
            done       <= 1'b1;
          end else begin
            state_reg <= g_step[STEPS-1].s_out;
            key_reg   <= g_step[STEPS-1].k_out;
            round_reg <= round_reg + 4'(STEPS);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_encryptor.sv
// Scoreboard bench for aes128_encryptor: directed vectors queued at start, checked when done rises.
module tb_aes128_encryptor;

`ifdef AES_UNROLL2_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 11;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] plaintext, key, ciphertext;
  logic         done;

  aes128_encryptor dut (
    .clk(clk), .rst(rst), .start(start), .plaintext(plaintext),
    .key(key), .ciphertext(ciphertext), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] ct;
    int           cyc0;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   fails = 0;
  bit   done_prev = 1'b0;

  localparam logic [127:0] V1_PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] V1_K  = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] V1_CT = 128'hff0b844a0853bf7c6934ab4364148fb9;
  localparam logic [127:0] V2_PT = 128'h636f6d7061726368636f6d7061726368;
  localparam logic [127:0] V2_K  = 128'h6772696666696e746772696666696e74;
  localparam logic [127:0] V2_CT = 128'h27a15792bba1cb6cba23475fdaa1cb1a;
  localparam logic [127:0] F1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] F1_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] F2_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] F2_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F2_CT = 128'h3925841d02dc09fbdc118597196a0b32;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: a rising done retires the oldest outstanding block.
  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL spurious_done: got done=1 ct=%h expected no outstanding block", ciphertext);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_ct"}, ciphertext, e.ct);
          chk({e.name, "_latency"}, 128'(cyc - e.cyc0), 128'(LAT));
          $display("txn %s: ct=%h latency=%0d", e.name, ciphertext, cyc - e.cyc0);
        end
      end
      done_prev = done;
    end
  end

  task automatic issue(input logic [127:0] pt, input logic [127:0] k,
                       input logic [127:0] ct, input string nm);
    logic         pd;
    logic [127:0] pc;
    @(negedge clk);
    plaintext = pt;
    key       = k;
    start     = 1'b1;
    pd        = done;
    pc        = ciphertext;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{ct, cyc, nm});
    if (pd) begin
      chk({nm, "_done_drop"}, 128'(done), 128'(0));
      chk({nm, "_ct_hold"}, ciphertext, pc);
    end
  endtask

  task automatic wait_sb(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got no done within 40 cycles expected done after %0d", nm, LAT);
      sb.delete();
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    plaintext = '0;
    key       = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_ct", ciphertext, 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(V1_PT, V1_K, V1_CT, "vec1");    wait_sb("vec1");
    issue(V2_PT, V2_K, V2_CT, "vec2");    wait_sb("vec2");
    issue(F1_PT, F1_K, F1_CT, "fips_c1"); wait_sb("fips_c1");
    issue(F2_PT, F2_K, F2_CT, "fips_b");  wait_sb("fips_b");

    // Inputs change and a second start arrives mid-RUN; the first block must be unaffected.
    issue(V2_PT, V2_K, V2_CT, "vec2_midrun");
    repeat (2) @(negedge clk);
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    key       = {$urandom, $urandom, $urandom, $urandom};
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    plaintext = F1_PT;
    key       = F2_K;
    wait_sb("vec2_midrun");
    repeat (15) @(negedge clk);
    chk("fin_done_hold", 128'(done), 128'(1));
    chk("fin_ct_hold", ciphertext, V2_CT);

    // Asynchronous reset in the middle of a block aborts it.
    issue(F1_PT, F1_K, F1_CT, "abort");
    sb.delete();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_ct", ciphertext, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 128'(done), 128'(0));

    issue(V1_PT, V1_K, V1_CT, "vec1_after_reset"); wait_sb("vec1_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
